// File: rtl/uart_pkg.sv
// Shared types and timing constants for the oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int         OVERSAMPLE = 8;
    localparam logic [2:0] VOTE_T0    = 3'd3;
    localparam logic [2:0] VOTE_T1    = 3'd4;
    localparam logic [2:0] VOTE_T2    = 3'd5;
    localparam logic [2:0] LAST_T     = 3'd7;
    localparam logic [2:0] LAST_BIT   = 3'd7;

    // Two-of-three majority used to decide every serial bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one tick every CLK_FREQ/(BAUD*OVERSAMPLING) clocks.
// Held in phase reset while en_i is low so each frame starts on a fresh phase.
module baud_tick_gen #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLING);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote and a valid/ready byte port.
// Optional parity bit and parity_err_o when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200
`ifdef UART_RX_PARITY_EN
   ,parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
`ifdef UART_RX_PARITY_EN
   ,output logic       parity_err_o
`endif
);

    rx_state_t  state_q, state_d;
    logic       sync1_q, sync2_q;
    logic       prev_q;
    logic [2:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       smp0_q, smp0_d;
    logic       smp1_q, smp1_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic       par_bit_q, par_bit_d;
    logic       parity_err_q, parity_err_d;
`endif
    logic       rxs;
    logic       tick;
    logic       vote;
    logic       byte_done;
    logic       handshake;

    assign rxs       = sync2_q;
    assign busy_o    = (state_q != IDLE);
    assign vote      = maj3(smp0_q, smp1_q, rxs);
    assign handshake = valid_q & ready_i;

    baud_tick_gen #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .OVERSAMPLING(OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (busy_o),
        .tick_o(tick)
    );

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        smp0_d      = smp0_q;
        smp1_d      = smp1_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        if (state_q == IDLE) begin
            // prev_q resets to 0, so a line held low through reset is never a start
            if (prev_q && !rxs) begin
                state_d = START;
                tcnt_d  = '0;
                bcnt_d  = '0;
            end
        end else if (tick) begin
            tcnt_d = tcnt_q + 3'd1;
            if (tcnt_q == VOTE_T0) smp0_d = rxs;
            if (tcnt_q == VOTE_T1) smp1_d = rxs;
            case (state_q)
                START: begin
                    if (tcnt_q == VOTE_T2 && vote) begin
                        state_d = IDLE;
                    end else if (tcnt_q == LAST_T) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (tcnt_q == VOTE_T2) shift_d = {vote, shift_q[7:1]};
                    if (tcnt_q == LAST_T) begin
                        if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tcnt_q == VOTE_T2) par_bit_d = vote;
                    if (tcnt_q == LAST_T) state_d = STOP;
                end
`endif
                STOP: begin
                    // Leave mid stop bit so an early next start edge is not missed
                    if (tcnt_q == VOTE_T2) begin
                        state_d = IDLE;
                        if (!vote) begin
                            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^{shift_q, par_bit_q}) != PARITY_ODD) begin
                            parity_err_d = 1'b1;
`endif
                        end else begin
                            byte_done = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output holding register; a newly completed byte wins over a handshake drop.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (handshake) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            smp0_q      <= 1'b0;
            smp1_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            smp0_q      <= smp0_d;
            smp1_q      <= smp1_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clk/bit; expected events queued by stimulus,
// consumed by a negedge monitor on handshake / error pulses.
module tb_uart_rx;

    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx #(
        .CLK_FREQ(1843200),
        .BAUD    (115200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
`ifdef UART_RX_PARITY_EN
       ,.parity_err_o(parity_err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%02h, expected none", kind, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_DATA && e.data !== d)) begin
                errors++;
                $display("FAIL event: got kind %0d data 0x%02h, expected kind %0d data 0x%02h",
                         kind, d, e.kind, e.data);
            end else begin
                $display("event kind %0d data 0x%02h ok", kind, d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o && ready_i) observe(K_DATA, data_o);
            if (frame_err_o) observe(K_FERR, 8'h00);
`ifdef UART_RX_PARITY_EN
            if (parity_err_o) observe(K_PERR, 8'h00);
`endif
        end
    end

    task automatic bit_time();
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input bit use_par, input logic par);
        rx_i = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            bit_time();
        end
        if (use_par) begin
            rx_i = par;
            bit_time();
        end
        rx_i = stop_v;
        bit_time();
        rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending events, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_data", {24'd0, data_o}, 32'd0);
        check("post_reset_flags", {29'd0, overrun_o, frame_err_o, valid_o}, 32'd0);
        @(posedge clk); #1;

        // two back-to-back bytes with consumer always ready
        ready_i = 1'b1;
        push(K_DATA, 8'h55);
        push(K_DATA, 8'hA3);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        drain("bytes_55_a3");
        check("no_overrun_a", {31'd0, overrun_o}, 32'd0);

        // overrun: second byte arrives while first is still held
        ready_i = 1'b0;
        push(K_DATA, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check("overrun_set", {31'd0, overrun_o}, 32'd1);
        check("held_data", {24'd0, data_o}, 32'h3C);
        check("held_valid", {31'd0, valid_o}, 32'd1);
        ready_i = 1'b1;
        drain("overrun_hs");
        repeat (2) @(posedge clk); #1;
        check("overrun_clear", {31'd0, overrun_o}, 32'd0);
        check("valid_clear", {31'd0, valid_o}, 32'd0);

        // 6-clock low glitch on idle line
        rx_i = 1'b0;
        repeat (6) @(posedge clk); #1;
        rx_i = 1'b1;
        check("glitch_busy_on", {31'd0, busy_o}, 32'd1);
        repeat (40) @(posedge clk); #1;
        check("glitch_busy_off", {31'd0, busy_o}, 32'd0);

        // framing error, then a good frame
        push(K_FERR, 8'h00);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        drain("frame_err");
        check("ferr_no_valid", {31'd0, valid_o}, 32'd0);
        push(K_DATA, 8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        drain("byte_7e");

        // reset in the middle of the data bits of 0xFF
        rx_i = 1'b0;
        bit_time();
        rx_i = 1'b1;
        bit_time();
        bit_time();
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;
        repeat (200) @(posedge clk); #1;
        check("midreset_outputs", {21'd0, data_o, overrun_o, frame_err_o, valid_o}, 32'd0);
        check("midreset_idle", {31'd0, busy_o}, 32'd0);
        push(K_DATA, 8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        drain("byte_12");

`ifdef UART_RX_PARITY_EN
        push(K_PERR, 8'h00);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        drain("parity_err");
        push(K_DATA, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        drain("parity_ok");
`endif

        repeat (20) @(posedge clk); #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
